// File: rtl/reg_file.sv
// Architectural register file: 32 x DATA_WIDTH, two async reads, one sync write.
// r0 reads zero; r29 (sp) resets to SP_INIT.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = 32'h0000_03FC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam logic [4:0] SP = 5'd29;

  logic [DATA_WIDTH-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (5'(i) == SP) ? SP_INIT : '0;
      end
    end else if (reg_write && write_reg != 5'd0) begin
      regs[write_reg] <= write_data;
    end
  end

  // no forwarding: reads see pre-edge state
  assign read_data1 = (read_reg1 == 5'd0) ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == 5'd0) ? '0 : regs[read_reg2];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// One task per scenario, inline compares.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int vecs = 0;
  int errs = 0;

  reg_file dut (
    .clk(clk),
    .rst(rst),
    .read_reg1(read_reg1),
    .read_reg2(read_reg2),
    .write_reg(write_reg),
    .write_data(write_data),
    .reg_write(reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_reg = a;
    write_data = d;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b0;
    reg_write = 1'b1;
    write_reg = 5'd5;
    write_data = 32'hDEAD_BEEF;
    read_reg2 = 5'd0;
    tick();
    tick();
    rst = 1'b1;
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      #1;
      exp = (i == 29) ? 32'h0000_03FC : 32'h0;
      vecs++;
      if (read_data1 !== exp) begin
        errs++;
        $display("FAIL reset r%0d got %h want %h", i, read_data1, exp);
      end
    end
    read_reg2 = 5'd5;
    #1;
    vecs++;
    if (read_data2 !== 32'h0) begin
      errs++;
      $display("FAIL reset_r5 got %h want 0", read_data2);
    end
  endtask

  task automatic test_basic();
    wr(5'd8, 32'h1234_5678);
    wr(5'd31, 32'hFFFF_FFFF);
    read_reg1 = 5'd8;
    read_reg2 = 5'd31;
    #1;
    vecs++;
    if (read_data1 !== 32'h1234_5678) begin
      errs++;
      $display("FAIL basic_r8 got %h want 12345678", read_data1);
    end
    vecs++;
    if (read_data2 !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL basic_r31 got %h want ffffffff", read_data2);
    end
  endtask

  task automatic test_r0();
    wr(5'd0, 32'hA5A5_A5A5);
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    #1;
    vecs++;
    if (read_data1 !== 32'h0) begin
      errs++;
      $display("FAIL r0_p1 got %h want 0", read_data1);
    end
    vecs++;
    if (read_data2 !== 32'h0) begin
      errs++;
      $display("FAIL r0_p2 got %h want 0", read_data2);
    end
  endtask

  task automatic test_wen();
    wr(5'd3, 32'h0000_0011);
    write_data = 32'h0000_0022;
    write_reg = 5'd3;
    reg_write = 1'b0;
    read_reg1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (read_data1 !== 32'h0000_0011) begin
        errs++;
        $display("FAIL wen_hold%0d got %h want 11", i, read_data1);
      end
    end
    // other registers untouched
    read_reg2 = 5'd8;
    #1;
    vecs++;
    if (read_data2 !== 32'h1234_5678) begin
      errs++;
      $display("FAIL wen_r8 got %h want 12345678", read_data2);
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd10, 32'h1);
    read_reg1 = 5'd10;
    read_reg2 = 5'd10;
    @(negedge clk);
    write_reg = 5'd10;
    write_data = 32'h2;
    reg_write = 1'b1;
    #1;
    vecs++;
    if (read_data1 !== 32'h1) begin
      errs++;
      $display("FAIL rw_before got %h want 1", read_data1);
    end
    tick();
    vecs++;
    if (read_data1 !== 32'h2) begin
      errs++;
      $display("FAIL rw_after got %h want 2", read_data1);
    end
    vecs++;
    if (read_data2 !== 32'h2) begin
      errs++;
      $display("FAIL rw_p2 got %h want 2", read_data2);
    end
    write_data = 32'h3;
    tick();
    vecs++;
    if (read_data1 !== 32'h3) begin
      errs++;
      $display("FAIL b2b_3 got %h want 3", read_data1);
    end
    write_data = 32'h4;
    tick();
    reg_write = 1'b0;
    vecs++;
    if (read_data1 !== 32'h4) begin
      errs++;
      $display("FAIL b2b_4 got %h want 4", read_data1);
    end
  endtask

  task automatic test_midreset();
    wr(5'd29, 32'h0000_0100);
    wr(5'd4, 32'h77);
    read_reg1 = 5'd29;
    read_reg2 = 5'd4;
    #1;
    vecs++;
    if (read_data1 !== 32'h0000_0100 || read_data2 !== 32'h77) begin
      errs++;
      $display("FAIL pre_rst got %h/%h want 100/77", read_data1, read_data2);
    end
    rst = 1'b0;
    write_reg = 5'd4;
    write_data = 32'h99;
    reg_write = 1'b1;
    tick();
    rst = 1'b1;
    reg_write = 1'b0;
    vecs++;
    if (read_data1 !== 32'h0000_03FC) begin
      errs++;
      $display("FAIL mid_sp got %h want 3fc", read_data1);
    end
    vecs++;
    if (read_data2 !== 32'h0) begin
      errs++;
      $display("FAIL mid_r4 got %h want 0", read_data2);
    end
    wr(5'd4, 32'h55);
    vecs++;
    if (read_data2 !== 32'h55) begin
      errs++;
      $display("FAIL resume_r4 got %h want 55", read_data2);
    end
  endtask

  initial begin
    rst = 1'b1;
    read_reg1 = '0;
    read_reg2 = '0;
    write_reg = '0;
    write_data = '0;
    reg_write = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_r0();
    test_wen();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle datapath. It stores 32 general-purpose 32-bit registers and provides two asynchronous read ports and one synchronous write port. The 5-bit write address comes from the destination-register select path, which chooses between rt, rd and the link register 31. Register 0 is hardwired to zero, and register 29 (stack pointer) resets to a programmable value.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- SP_INIT, 32'h0000_03FC, reset value of register 29

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
- read_reg1  input  5  address of read port 1 (rs)
- read_reg2  input  5  address of read port 2 (rt)
- write_reg  input  5  write address (output of destination-register select)
- write_data  input  DATA_WIDTH  value to write
- reg_write  input  1  write enable, active-high
- read_data1  output  DATA_WIDTH  contents of register read_reg1
- read_data2  output  DATA_WIDTH  contents of register read_reg2

## Operation
- Storage is 32 entries × DATA_WIDTH, indexed 0–31.
- **Reset:** on a rising edge with rst=0:
  - all registers are cleared to 0;
  - register 29 is set to SP_INIT;
  - reg_write is ignored in that cycle; reset has priority over the write.
- **Write:** on a rising edge with rst=1, reg_write=1 and write_reg≠0, register[write_reg] takes write_data. All other registers hold their values.
- Writes with write_reg=0 are discarded. Register 0 reads 0 at all times.
- reg_write=0 leaves all registers unchanged, whatever the value of write_reg or write_data.
- **Reads:** asynchronous and combinational. read_dataN = register[read_regN], or 0 if read_regN=0.
- Each read port is independent. Both ports may address the same register and then both return the same value.
- **No internal forwarding.** A read of the register being written returns the old value until the rising edge, then the new value. This avoids a combinational loop through the ALU in the single-cycle datapath.
- Writes to register 29 are normal writes; SP_INIT applies only at reset.
- X or Z on read_reg inputs need not be handled. Verification drives only defined addresses.

## Timing
- Write latency: one edge. Data present at edge k is visible on a read port just after edge k.
- Read latency: zero cycles (combinational from read_reg and stored state).
- **Reset value of outputs:** after a reset edge, read_data1 and read_data2 are 0 for every address except 29, which returns SP_INIT.
- Before the first reset edge, register contents are undefined and outputs may be X.
- **Reset asserted mid-program:** the next edge clears all state, even with reg_write=1 in that same cycle. Normal writes resume on the first edge with rst=1.
- **Back-to-back writes to the same address:** the last one wins, one per edge.
- **Simultaneous write and read of the same address:** the read returns the pre-edge value during the cycle and the post-edge value after the edge.
- Setup requirement: write_reg, write_data and reg_write must be stable before the rising edge. rst is sampled only at the edge, so an rst glitch between edges has no effect.

## Test plan
- **Reset values:** hold rst=0 for 2 edges with reg_write=1, write_reg=5, write_data=32'hDEAD_BEEF. Then release rst and sweep read_reg1 over 0–31. Expect 0 everywhere except read_data1=32'h0000_03FC at address 29; register 5 stays 0.
- **Basic write/read:** write 32'h1234_5678 to register 8 and 32'hFFFF_FFFF to register 31 (link). Then set read_reg1=8 and read_reg2=31. Expect read_data1=32'h1234_5678 and read_data2=32'hFFFF_FFFF.
- **Register 0 protection:** write 32'hA5A5_A5A5 with write_reg=0 and reg_write=1. Expect read_data1=0 and read_data2=0 with both ports addressing 0.
- **Write-enable gating:** write 32'h0000_0011 to register 3. Then drive write_data=32'h0000_0022, write_reg=3, reg_write=0 for 3 edges. Expect register 3 to remain 32'h0000_0011.
- **Same-cycle read/write ordering:** with register 10=32'h0000_0001, drive reg_write=1, write_reg=10, write_data=32'h0000_0002, read_reg1=10. Expect read_data1=1 before the edge and 2 after it. Follow with writes of 3 then 4 on consecutive edges; expect 4.
- **Mid-run reset with stack pointer:** write 32'h0000_0100 to register 29 and 32'h77 to register 4. Assert rst=0 for one edge with reg_write=1, write_reg=4, write_data=32'h99. Expect register 29=32'h0000_03FC and register 4=0 after that edge.
